// File: rtl/button_event_pkg.sv
// Shared types and elaboration helpers for the button event generator.
// Holds the autorepeat state encoding, counter sizing and parameter legality check.
package button_event_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } repeat_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned count_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic bit params_legal(input int unsigned width,
                                        input int unsigned debounce_cycles,
                                        input int unsigned repeat_period);
        return (width >= 1) && (debounce_cycles >= 1) && (repeat_period >= 1);
    endfunction

endpackage

// File: rtl/button_event_channel.sv
// One button channel: synchronizer, debouncer, pending press/release flags,
// tick-aligned emission and the autorepeat state machine.
module button_event_channel
    import button_event_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 30,
    parameter int unsigned REPEAT_PERIOD   = 6
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int unsigned DB_W  = count_width(DEBOUNCE_CYCLES);
    localparam int unsigned CNT_W = count_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
    localparam bit          REPEAT_EN = (REPEAT_DELAY != 0);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_END  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_END = CNT_W'(REPEAT_PERIOD);

    logic [1:0]       sync_q;
    logic             btn_s;
    logic [DB_W-1:0]  db_cnt;
    logic             level_q;
    logic             level_d;
    logic             rise;
    logic             fall;
    logic             press_pend;
    logic             rel_pend;
    logic             press_emit;
    logic             rpt_fire;
    repeat_state_e    state;
    repeat_state_e    state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;

    assign btn_s      = sync_q[1];
    assign rise       = level_q & ~level_d;
    assign fall       = ~level_q & level_d;
    assign press_emit = press_pend | rise;
    assign level_o    = level_q;

    // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            db_cnt  <= '0;
            level_q <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_d <= level_q;
            if (btn_s == level_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level_q <= ~level_q;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            press_pend <= 1'b0;
            rel_pend   <= 1'b0;
            press_o    <= 1'b0;
            release_o  <= 1'b0;
            repeat_o   <= 1'b0;
        end else begin
            press_o   <= tick_i & (press_emit | rpt_fire);
            release_o <= tick_i & (rel_pend | fall);
            repeat_o  <= rpt_fire;
            if (tick_i) begin
                press_pend <= 1'b0;
                rel_pend   <= 1'b0;
            end else begin
                press_pend <= press_pend | rise;
                rel_pend   <= rel_pend | fall;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Counts ticks while held; a dropped level always returns to IDLE.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rpt_fire = 1'b0;
        cnt_inc  = cnt + 1'b1;
        if (!level_q) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (tick_i) begin
            case (state)
                IDLE: begin
                    if (press_emit && REPEAT_EN) begin
                        state_n = DELAY;
                        cnt_n   = '0;
                    end
                end
                DELAY: begin
                    if (cnt_inc == DELAY_END) begin
                        rpt_fire = 1'b1;
                        state_n  = REPEAT;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                REPEAT: begin
                    if (cnt_inc == PERIOD_END) begin
                        rpt_fire = 1'b1;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_event_gen.sv
// Turns raw bouncing push-button levels into clean, game-tick-aligned
// press / release / autorepeat events, one independent channel per button.
module button_event_gen
    import button_event_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 30,
    parameter int unsigned REPEAT_PERIOD   = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] btn_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] press_o,
    output logic [WIDTH-1:0] release_o,
    output logic [WIDTH-1:0] repeat_o
);

    if (!params_legal(WIDTH, DEBOUNCE_CYCLES, REPEAT_PERIOD)) begin : g_bad_params
        $error("button_event_gen: WIDTH, DEBOUNCE_CYCLES and REPEAT_PERIOD must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        button_event_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .tick_i   (tick_i),
            .btn_i    (btn_i[i]),
            .level_o  (level_o[i]),
            .press_o  (press_o[i]),
            .release_o(release_o[i]),
            .repeat_o (repeat_o[i])
        );
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen: reset table, directed corner
// sequences and randomized button traffic against a window/tick-count model.
module tb_button_event_gen;

    localparam int W  = 4;
    localparam int DC = 4;
    localparam int RD = 3;
    localparam int RP = 2;
    localparam int HN = 8192;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         tick_i = 1'b0;
    logic [W-1:0] btn_i = '0;
    logic [W-1:0] level_o, press_o, release_o, repeat_o;

    always #5 clk = ~clk;

    button_event_gen #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .tick_i   (tick_i),
        .btn_i    (btn_i),
        .level_o  (level_o),
        .press_o  (press_o),
        .release_o(release_o),
        .repeat_o (repeat_o)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [W-1:0] cur_btn = '0;

    // Reference model: level flips once the last DC synchronized samples all
    // disagree with it; repeats fire at held-tick counts RD, RD+RP, RD+2RP...
    logic [W-1:0] hist [HN];
    int           min_valid = 0;
    bit           model_valid = 0;
    logic [W-1:0] m_lvl = '0, m_prev = '0, ppend = '0, rpend = '0, active = '0;
    logic [W-1:0] e_press = '0, e_rel = '0, e_rep = '0;
    int           held [W];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic r, input logic t, input logic [W-1:0] b, input int n);
        logic [W-1:0] nl;
        logic rise, fall, fire, flip;
        int idx;
        hist[n % HN] = b;
        if (r) begin
            hist[n % HN] = '0;
            if (n > 0) hist[(n - 1) % HN] = '0;
            min_valid = n - 1;
            m_lvl = '0; m_prev = '0; ppend = '0; rpend = '0; active = '0;
            e_press = '0; e_rel = '0; e_rep = '0;
            for (int c = 0; c < W; c++) held[c] = 0;
            model_valid = 1;
        end else begin
            nl = m_lvl;
            for (int c = 0; c < W; c++) begin
                rise = m_lvl[c] && !m_prev[c];
                fall = !m_lvl[c] && m_prev[c];
                e_press[c] = 1'b0; e_rel[c] = 1'b0; e_rep[c] = 1'b0;
                if (t) begin
                    fire = 1'b0;
                    if (m_lvl[c] && active[c]) begin
                        held[c]++;
                        fire = (held[c] == RD) || (held[c] > RD && ((held[c] - RD) % RP) == 0);
                    end
                    e_press[c] = ppend[c] | rise | fire;
                    e_rel[c]   = rpend[c] | fall;
                    e_rep[c]   = fire;
                    if (m_lvl[c] && !active[c] && (ppend[c] || rise) && RD != 0) begin
                        active[c] = 1'b1;
                        held[c] = 0;
                    end
                    ppend[c] = 1'b0;
                    rpend[c] = 1'b0;
                end else begin
                    ppend[c] = ppend[c] | rise;
                    rpend[c] = rpend[c] | fall;
                end
                if (!m_lvl[c]) begin
                    active[c] = 1'b0;
                    held[c] = 0;
                end
                flip = 1'b1;
                for (int k = 0; k < DC; k++) begin
                    idx = n - 2 - k;
                    if (idx < 0 || idx < min_valid || hist[idx % HN][c] == m_lvl[c]) flip = 1'b0;
                end
                if (flip) nl[c] = ~m_lvl[c];
            end
            m_prev = m_lvl;
            m_lvl = nl;
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, compare at negedge.
    task automatic cycle(input logic r, input logic t, input logic [W-1:0] b);
        rst_i = r; tick_i = t; btn_i = b;
        @(posedge clk);
        model_edge(r, t, b, cyc);
        @(negedge clk);
        cyc++;
        if (model_valid)
            check("model", {16'h0, level_o, press_o, release_o, repeat_o},
                  {16'h0, m_lvl, e_press, e_rel, e_rep});
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0, (cyc % 10) == 9, cur_btn);
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < 10 && (cyc % 10) != phase; i++) run(1);
    endtask

    typedef struct {
        logic         rst;
        logic         tick;
        logic [W-1:0] btn;
        logic         chk;
        logic [W-1:0] lvl, prs, rel, rep;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, %0d vectors so far", vectors);
        $fatal(1);
    end

    initial begin
        int k, np, nr, base, r0, t_exp, p1, p2;
        logic rep1, rep2, found;
        logic [9:0] pmask, rmask;

        // Reset with all buttons held, then release reset and wait for the press.
        for (int i = 0; i < 14; i++) tbl[i] = '{1'b0, 1'b0, 4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 5; i++) tbl[i].rst = 1'b1;
        tbl[10].lvl = 4'hF;
        tbl[11].lvl = 4'hF;
        tbl[12] = '{1'b0, 1'b1, 4'hF, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0};
        tbl[13].lvl = 4'hF;
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].rst, tbl[i].tick, tbl[i].btn);
            if (tbl[i].chk)
                check($sformatf("tbl%0d", i), {16'h0, level_o, press_o, release_o, repeat_o},
                      {16'h0, tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].rep});
        end
        cur_btn = '0;
        run(40);

        // Bouncing bit 0: no level change while toggling, then 6-cycle latency.
        for (int i = 0; i < 20; i++) begin
            cur_btn[0] = ((i / 2) % 2) == 0;
            run(1);
        end
        check("toggle_quiet", {28'h0, level_o}, 32'h0);
        cur_btn[0] = 1'b1;
        run(1);
        k = 1;
        while (!level_o[0] && k < 20) begin
            run(1);
            k++;
        end
        check("toggle_latency", k, 6);
        check("toggle_others", {29'h0, level_o[3:1]}, 32'h0);
        cur_btn = '0;
        run(40);

        // Short tap on bit 1 fully inside one tick interval.
        align(4);
        cur_btn[1] = 1'b1;
        run(8);
        cur_btn[1] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            run(1);
            if (press_o[1]) found = 1'b1;
        end
        check("tap_press_seen", found, 1);
        check("tap_release_same_cycle", release_o[1], 1);
        check("tap_not_repeat", repeat_o[1], 0);
        np = 0;
        for (int i = 0; i < 50; i++) begin
            run(1);
            if (press_o[1]) np++;
        end
        check("tap_no_later_press", np, 0);

        // Long hold on bit 2: presses at T0,T3,T5,T7,T9.
        align(0);
        base = cyc;
        cur_btn[2] = 1'b1;
        pmask = '0; rmask = '0;
        for (int i = 0; i < 100; i++) begin
            run(1);
            if (press_o[2] && (cyc - base) >= 10 && ((cyc - base - 10) / 10) < 10) begin
                pmask[(cyc - base - 10) / 10] = 1'b1;
                rmask[(cyc - base - 10) / 10] = repeat_o[2];
            end
        end
        check("hold_press_ticks", pmask, 10'b10_1010_1001);
        check("hold_repeat_ticks", rmask, 10'b10_1010_1000);
        cur_btn[2] = 1'b0;
        np = 0; nr = 0;
        for (int i = 0; i < 40; i++) begin
            run(1);
            if (press_o[2]) np++;
            if (release_o[2]) nr++;
        end
        check("hold_release_once", nr, 1);
        check("hold_no_press_after", np, 0);

        // Debounced rise of bit 3 on the very tick cycle.
        align(3);
        base = cyc;
        cur_btn[3] = 1'b1;
        run(7);
        check("coincide_press", {30'h0, press_o[3], repeat_o[3]}, 32'h2);
        run(10);
        check("coincide_nothing_pending", press_o[3], 0);
        cur_btn[3] = 1'b0;
        run(40);

        // Reset while bit 2 is autorepeating and still held.
        align(0);
        cur_btn[2] = 1'b1;
        run(40);
        check("pre_reset_repeat", {30'h0, press_o[2], repeat_o[2]}, 32'h3);
        cycle(1'b1, (cyc % 10) == 9, cur_btn);
        check("reset_outputs", {16'h0, level_o, press_o, release_o, repeat_o}, 32'h0);
        r0 = cyc;
        t_exp = r0 + 6;
        while ((t_exp % 10) != 9) t_exp++;
        p1 = -1; p2 = -1; rep1 = 1'b1; rep2 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            run(1);
            if (press_o[2]) begin
                if (p1 < 0) begin p1 = cyc; rep1 = repeat_o[2]; end
                else if (p2 < 0) begin p2 = cyc; rep2 = repeat_o[2]; end
            end
        end
        check("post_reset_press_cycle", p1, t_exp + 1);
        check("post_reset_press_not_repeat", rep1, 0);
        check("post_reset_first_repeat_gap", p2 - p1, 30);
        check("post_reset_first_repeat_flag", rep2, 1);
        cur_btn = '0;
        run(40);

        // Random traffic: mixes glitches, taps, long holds and rare resets.
        begin
            int hold [W];
            for (int c = 0; c < W; c++) hold[c] = $urandom_range(1, 80);
            for (int i = 0; i < 2000; i++) begin
                for (int c = 0; c < W; c++) begin
                    if (hold[c] == 0) begin
                        cur_btn[c] = ~cur_btn[c];
                        hold[c] = $urandom_range(1, 80);
                    end else begin
                        hold[c]--;
                    end
                end
                cycle(($urandom % 400) == 0, (cyc % 10) == 9, cur_btn);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
